// File: rtl/act_pkg.sv
// act_pkg -- shared types and helpers for the vec_activation datapath.
//
// Contents:
//   act_mode_e  : per-vector activation select (RELU, LEAKY, CLIP, BYPASS)
//   num_chunks(): beats per vector for a given vector length and lane count
package act_pkg;

    typedef enum logic [1:0] {
        ACT_RELU   = 2'd0,
        ACT_LEAKY  = 2'd1,
        ACT_CLIP   = 2'd2,
        ACT_BYPASS = 2'd3
    } act_mode_e;

    // Vector length is required to be a whole number of beats.
    function automatic int num_chunks(input int vec_len, input int lanes);
        return vec_len / lanes;
    endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane -- combinational single-element activation.
//
// Parameters: DataWidth (signed element width), ClipMax (CLIP ceiling),
//             LeakShift (arithmetic shift applied to negatives in LEAKY).
// Ports:
//   mode   in  2          activation select (act_mode_e encoding)
//   x      in  DataWidth  signed input element
//   y      out DataWidth  activated element (same width, cannot overflow)
//   zeroed out 1          RELU/CLIP forced a negative to 0, or CLIP saturated
module act_lane
    import act_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int ClipMax   = 6 << 4,
    parameter int LeakShift = 3
) (
    input  logic [1:0]           mode,
    input  logic [DataWidth-1:0] x,
    output logic [DataWidth-1:0] y,
    output logic                 zeroed
);

    localparam logic signed [DataWidth-1:0] CLIP_V = DataWidth'(ClipMax);

    logic signed [DataWidth-1:0] xs;
    logic                        neg;
    logic                        over;

    assign xs   = $signed(x);
    assign neg  = xs[DataWidth-1];
    assign over = (xs > CLIP_V);

    // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        y      = x;
        zeroed = 1'b0;
        case (act_mode_e'(mode))
            ACT_RELU: begin
                if (neg) begin
                    y      = '0;
                    zeroed = 1'b1;
                end
            end
            ACT_LEAKY: begin
                // Arithmetic shift floors toward -inf, so small negatives stay at -1.
                if (neg) y = xs >>> LeakShift;
            end
            ACT_CLIP: begin
                if (neg) begin
                    y      = '0;
                    zeroed = 1'b1;
                end else if (over) begin
                    y      = CLIP_V;
                    zeroed = 1'b1;
                end
            end
            default: y = x;
        endcase
    end

endmodule

// File: rtl/vec_activation.sv
// vec_activation -- chunked elementwise activation over a valid/ready stream.
//
// A vector of InVecLength signed elements arrives WorkingRegs lanes per beat.
// The activation mode is captured on the first beat of each vector and held
// for the rest of it. Results leave through one back-pressurable register.
//
// Optional build macro: ACT_STATS_EN adds zeroed_count / stats_valid.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   mode_in    in  2      activation select, sampled on a vector's first beat
//   in_valid / in_ready   input handshake
//   in_data    in  W*D    lanes, lane 0 in the low bits
//   out_valid / out_ready output handshake
//   out_data   out W*D    activated lanes
//   out_first/out_last    beat is the first / last chunk of its vector
//   busy       out 1      a vector is partially accepted
//   zeroed_count, stats_valid (ACT_STATS_EN only) per-vector zero/clip count
module vec_activation
    import act_pkg::*;
#(
    parameter int InVecLength = 64,
    parameter int WorkingRegs = 4,
    parameter int DataWidth   = 8,
    parameter int ClipMax     = 6 << 4,
    parameter int LeakShift   = 3
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [1:0]                       mode_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WorkingRegs*DataWidth-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WorkingRegs*DataWidth-1:0] out_data,
    output logic                             out_first,
    output logic                             out_last,
    output logic                             busy
`ifdef ACT_STATS_EN
    ,
    output logic [$clog2(InVecLength+1)-1:0] zeroed_count,
    output logic                             stats_valid
`endif
);

    localparam int NUM_CHUNKS = num_chunks(InVecLength, WorkingRegs);
    localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHUNKS - 1);

    typedef enum logic {S_IDLE, S_STREAM} state_e;

    state_e                         state_q, state_d;
    logic [CW-1:0]                  chunk_q, chunk_d;
    act_mode_e                      mode_q, mode_d;
    logic [1:0]                     cur_mode;
    logic                           accept;
    logic [WorkingRegs*DataWidth-1:0] act_data;
    logic [WorkingRegs-1:0]         lane_zeroed;

    // Single output stage: a new beat may enter whenever the register is empty
    // or is being drained in this same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign busy     = (chunk_q != '0);

    // The first beat of a vector uses mode_in directly; later beats use the latched copy.
    assign cur_mode = (state_q == S_IDLE) ? mode_in : mode_q;

    for (genvar i = 0; i < WorkingRegs; i++) begin : g_lane
        act_lane #(
            .DataWidth (DataWidth),
            .ClipMax   (ClipMax),
            .LeakShift (LeakShift)
        ) u_lane (
            .mode   (cur_mode),
            .x      (in_data[i*DataWidth +: DataWidth]),
            .y      (act_data[i*DataWidth +: DataWidth]),
            .zeroed (lane_zeroed[i])
        );
    end

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mode_d = act_mode_e'(mode_in);
                    if (NUM_CHUNKS > 1) begin
                        state_d = S_STREAM;
                        chunk_d = CW'(1);
                    end
                end
            end
            S_STREAM: begin
                if (accept) begin
                    if (chunk_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        chunk_d = '0;
                    end else begin
                        chunk_d = CW'(chunk_q + 1'b1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            chunk_q <= '0;
            mode_q  <= ACT_RELU;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            mode_q  <= mode_d;
        end
    end

    // NOTE: the data register is reset too, since out_data=0 is part of the visible reset state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= act_data;
            out_first <= (chunk_q == '0);
            out_last  <= (chunk_q == LAST_IDX);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ACT_STATS_EN
    localparam int SW = $clog2(InVecLength + 1);

    logic [SW-1:0] beat_zeros;
    logic [SW-1:0] stat_q;

    always_comb begin
        beat_zeros = '0;
        for (int i = 0; i < WorkingRegs; i++) begin
            beat_zeros = beat_zeros + SW'(lane_zeroed[i]);
        end
    end

    // Accumulator restarts on chunk 0; after the last beat is accepted it
    // holds the full-vector total, which stays put while out_last is presented.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stat_q <= '0;
        end else if (accept) begin
            stat_q <= ((chunk_q == '0) ? '0 : stat_q) + beat_zeros;
        end
    end

    assign zeroed_count = stat_q;
    assign stats_valid  = out_valid && out_ready && out_last;
`else
    // Lane flags only feed the stats counter, absent in this build.
    logic unused_zeroed;
    assign unused_zeroed = ^lane_zeroed;
`endif

endmodule

// File: doc/vec_activation.md
# vec_activation

Chunked, parametrised elementwise activation unit for the inference datapath: the successor to the fixed 8-bit ReLU stage. It accepts a vector of `InVecLength` signed elements, `WorkingRegs` elements per beat, over a valid/ready handshake. It applies a per-vector selectable activation (ReLU, leaky ReLU, clipped ReLU, bypass) and streams the result out through a registered, back-pressurable output with first/last chunk markers. It sits between a matmul/accumulator stage and the next layer's input FIFO.

## Interface
- `InVecLength`, 64: elements per vector; must be a multiple of `WorkingRegs`.
- `WorkingRegs`, 4: elements per beat (lanes).
- `DataWidth`, 8: signed element width.
- `ClipMax`, 6 << 4: clip ceiling for CLIP mode. Representable positive value, ≥0.
- `LeakShift`, 3: arithmetic right-shift applied to negatives in LEAKY mode; 1..DataWidth-1.
- `clk_in`  in  1  sole clock; all logic on the rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `mode_in`  in  2  activation select (`act_mode_e`); sampled only on a vector's first accepted beat.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`.
- `in_data`  in  WorkingRegs×DataWidth  signed lanes, lane 0 = lowest element index.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  WorkingRegs×DataWidth  activated lanes.
- `out_first` / `out_last`  out  1  beat is chunk 0 / chunk NumChunks-1 of its vector.
- `busy`  out  1  a vector is partially accepted (chunk counter ≠ 0).

## Operation
- NumChunks = InVecLength / WorkingRegs.
- Two states:
  - IDLE (chunk_idx = 0): an accepted beat latches `mode_in` into `mode_q` and moves to STREAM. If NumChunks = 1 it stays in IDLE.
  - STREAM: each accepted beat increments chunk_idx. The beat at NumChunks-1 wraps chunk_idx to 0 and returns to IDLE.
- A `mode_in` change mid-vector is ignored until the next vector.
- Per-lane function on signed x:
  - RELU (0): x<0 ? 0 : x.
  - LEAKY (1): x<0 ? x>>>LeakShift : x. Rounds toward −∞, so −1 maps to −1 and −8 maps to −1 with shift 3.
  - CLIP (2): x<0 ? 0 : (x>ClipMax ? ClipMax : x).
  - BYPASS (3): x.
- Output width equals input width; no function can overflow.
- Output is a single register stage: `in_ready = !out_valid || out_ready`, combinational from `out_ready`.
- The first/last flags are registered alongside the data.
- Full throughput is 1 beat/cycle under continuous `out_ready`.

## Timing
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, i.e. one cycle.
- Under back-pressure (`out_valid && !out_ready`), `out_data`, `out_first` and `out_last` hold stable and `in_ready`=0.
- Simultaneous output accept and input accept in the same cycle replace the output register with no bubble.
- Reset values: `out_valid`=0, `out_data`=0, `out_first`=0, `out_last`=0, `busy`=0, `in_ready`=1, chunk_idx=0, `mode_q`=RELU, state IDLE.
- Reset mid-vector discards the partial vector and any held output beat. The next accepted beat is chunk 0.
- `in_valid` low between beats is legal; the counter advances only on accepted beats.

## Configuration
- `ACT_STATS_EN` defined adds two outputs:
  - `zeroed_count` [$clog2(InVecLength+1)-1:0]: number of lanes in the vector that RELU or CLIP forced to 0 from a negative input, plus the count CLIP saturated to ClipMax. It is registered and valid while `out_last` is presented.
  - `stats_valid`: 1-cycle pulse on the edge where the `out_last` beat is accepted.
  - Reset value of both is 0; the internal accumulator clears on each first beat.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `act_pkg`:
  - `typedef enum logic [1:0] act_mode_e {ACT_RELU, ACT_LEAKY, ACT_CLIP, ACT_BYPASS}`.
  - Helper constant function for NumChunks.
- One combinational sub-module, `act_lane`:
  - Parameters: DataWidth, ClipMax, LeakShift.
  - Inputs: mode, x. Outputs: y, zeroed flag.
  - Instantiated WorkingRegs times by generate.
- The top level holds the FSM, chunk counter, output register and optional stats.

## Test plan
- Default params except InVecLength=8, WorkingRegs=4; RELU; beats {−5, 0, 7, −128} then {127, −1, 3, 2} -> outputs {0, 0, 7, 0} (first=1) then {127, 0, 3, 2} (last=1), one cycle after each accept.
- LEAKY, LeakShift=3; {−8, −1, −128, 16} -> {−1, −1, −16, 16}.
- CLIP, ClipMax=96; {100, 96, −3, 50} -> {96, 96, 0, 50}. With `ACT_STATS_EN`, zeroed_count=2 after that vector's last beat, with a single `stats_valid` pulse.
- `mode_in` switched from RELU to BYPASS after the first beat -> the second beat is still ReLU'd; the next vector is bypassed.
- Hold `out_ready`=0 for 5 cycles with `in_valid`=1 -> `in_ready`=0, `out_data` stable. On release, consecutive beats flow at 1/cycle with no loss or duplication.
- Assert `rst_in` after chunk 0 is accepted -> `out_valid`=0, `busy`=0. The next beat is flagged `out_first`=1.
